id_ex_stage: RTL and testbench

- ID/EX pipeline boundary of the pipelined MIPS core. Consumes the 32-bit sign-extended immediate, register-file read data, register indices and decoded control bundle produced in ID, and registers them for EX.
- Contains the load-use hazard detector.
  - Requests an IF/ID stall.
  - Injects a bubble when the instruction in EX is a load whose destination matches a source of the instruction in ID.

---
 rtl/mips_pipe_pkg.sv | 20 ++
 rtl/id_ex_stage_if.sv | 48 ++++
 rtl/load_use_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the pipelined MIPS core: control-bundle bit layout and widths.
// IMM_ZERO_EXT_EN, when defined, makes the ZEXT control bit meaningful in ID/EX.
package mips_pipe_pkg;

  localparam int CTRL_W     = 10;

  // Decoded control bundle layout; ALU_OP occupies the top three bits.
  localparam int MEM_READ   = 0;
  localparam int MEM_WRITE  = 1;
  localparam int REG_WRITE  = 2;
  localparam int BRANCH     = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int ZEXT       = 6;
  localparam int ALU_OP_LSB = 7;
  localparam int ALU_OP_W   = 3;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline boundary.
// master drives the ID side; slave is the pipeline register itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  import mips_pipe_pkg::*;

  logic                valid_i;
  logic                stall_i;
  logic                flush_i;
  logic [DATA_W-1:0]   pc_plus4_i;
  logic [DATA_W-1:0]   rs_data_i;
  logic [DATA_W-1:0]   rt_data_i;
  logic [DATA_W-1:0]   imm_ext_i;
  logic [REG_AW-1:0]   rs_i;
  logic [REG_AW-1:0]   rt_i;
  logic [REG_AW-1:0]   rd_i;
  logic [5:0]          funct_i;
  logic [CTRL_W-1:0]   ctrl_i;

  logic                valid_o;
  logic [DATA_W-1:0]   pc_plus4_o;
  logic [DATA_W-1:0]   rs_data_o;
  logic [DATA_W-1:0]   rt_data_o;
  logic [DATA_W-1:0]   imm_o;
  logic [REG_AW-1:0]   rs_o;
  logic [REG_AW-1:0]   rt_o;
  logic [REG_AW-1:0]   rd_o;
  logic [5:0]          funct_o;
  logic [CTRL_W-1:0]   ctrl_o;
  logic                load_use_stall_o;

  modport master (
    output valid_i, stall_i, flush_i, pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i,
           rs_i, rt_i, rd_i, funct_i, ctrl_i,
    input  valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
           funct_o, ctrl_o, load_use_stall_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i,
           rs_i, rt_i, rd_i, funct_i, ctrl_i,
    output valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
           funct_o, ctrl_o, load_use_stall_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
// Kept standalone so the IF/ID hold logic can reuse the same decision.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_reg_dst,
  output logic              stall
);

  logic id_uses_rt;
  logic rs_match;
  logic rt_match;

  // Stores, branches and R-type ops read rt as a source; other I-types write it.
  assign id_uses_rt = id_mem_write | id_branch | id_reg_dst;
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = (ex_rt == id_rt) & id_uses_rt;

  // A load into $0 never produces a value worth waiting for.
  assign stall = ex_valid & ex_mem_read & id_valid & (ex_rt != '0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// IMM_ZERO_EXT_EN: when defined, ctrl ZEXT selects a zero-extended 16-bit immediate.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  logic                valid_reg;
  logic [DATA_W-1:0]   pc_plus4_reg;
  logic [DATA_W-1:0]   rs_data_reg;
  logic [DATA_W-1:0]   rt_data_reg;
  logic [DATA_W-1:0]   imm_reg;
  logic [REG_AW-1:0]   rs_reg;
  logic [REG_AW-1:0]   rt_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic [5:0]          funct_reg;
  logic [CTRL_W-1:0]   ctrl_reg;

  logic [DATA_W-1:0]   imm_next;
  logic [CTRL_W-1:0]   ctrl_next;
  logic                load_use;

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .ex_valid     (valid_reg),
    .ex_mem_read  (ctrl_reg[MEM_READ]),
    .ex_rt        (rt_reg),
    .id_valid     (bus.valid_i),
    .id_rs        (bus.rs_i),
    .id_rt        (bus.rt_i),
    .id_mem_write (bus.ctrl_i[MEM_WRITE]),
    .id_branch    (bus.ctrl_i[BRANCH]),
    .id_reg_dst   (bus.ctrl_i[REG_DST]),
    .stall        (load_use)
  );

`ifdef IMM_ZERO_EXT_EN
  // andi/ori/xori want the raw 16-bit field, not the sign-extended one.
  assign imm_next = bus.ctrl_i[ZEXT] ? {{(DATA_W-16){1'b0}}, bus.imm_ext_i[15:0]}
                                     : bus.imm_ext_i;
`else
  assign imm_next = bus.imm_ext_i;
`endif

  // An empty ID slot must never carry controls into EX.
  assign ctrl_next = bus.valid_i ? bus.ctrl_i : NOP_CTRL;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg    <= 1'b0;
      pc_plus4_reg <= '0;
      rs_data_reg  <= '0;
      rt_data_reg  <= '0;
      imm_reg      <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      funct_reg    <= '0;
      ctrl_reg     <= NOP_CTRL;
    end else if (bus.flush_i) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= NOP_CTRL;
    end else if (bus.stall_i) begin
      valid_reg <= valid_reg;
    end else if (load_use) begin
      // IF/ID holds the dependent instruction, so only a bubble enters EX.
      valid_reg <= 1'b0;
      ctrl_reg  <= NOP_CTRL;
    end else begin
      valid_reg    <= bus.valid_i;
      pc_plus4_reg <= bus.pc_plus4_i;
      rs_data_reg  <= bus.rs_data_i;
      rt_data_reg  <= bus.rt_data_i;
      imm_reg      <= imm_next;
      rs_reg       <= bus.rs_i;
      rt_reg       <= bus.rt_i;
      rd_reg       <= bus.rd_i;
      funct_reg    <= bus.funct_i;
      ctrl_reg     <= ctrl_next;
    end
  end

  assign bus.valid_o          = valid_reg;
  assign bus.pc_plus4_o       = pc_plus4_reg;
  assign bus.rs_data_o        = rs_data_reg;
  assign bus.rt_data_o        = rt_data_reg;
  assign bus.imm_o            = imm_reg;
  assign bus.rs_o             = rs_reg;
  assign bus.rt_o             = rt_reg;
  assign bus.rd_o             = rd_reg;
  assign bus.funct_o          = funct_reg;
  assign bus.ctrl_o           = ctrl_reg;
  assign bus.load_use_stall_o = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed test-plan cases followed by random traffic.
// Define IMM_ZERO_EXT_EN for both bench and RTL to exercise the zero-extension path.
module tb_id_ex_stage;
  import mips_pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'((1 << REG_WRITE) | (1 << REG_DST) | (2 << ALU_OP_LSB));
  localparam logic [CTRL_W-1:0] C_LW   = CTRL_W'((1 << MEM_READ) | (1 << REG_WRITE) | (1 << ALU_SRC));
  localparam logic [CTRL_W-1:0] C_ORI  = CTRL_W'((1 << REG_WRITE) | (1 << ALU_SRC) | (1 << ZEXT) | (3 << ALU_OP_LSB));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic              rst, stall, flush, valid;
    logic [31:0]       pc, rsd, rtd, imm;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] ctrl;
  } stim_t;

  typedef struct {
    logic              valid;
    logic [31:0]       pc, rsd, rtd, imm;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] ctrl;
    logic              chk_data;
  } ex_t;

  ex_t   m;
  bit    m_known = 1'b0;
  ex_t   st_q[$];
  bit    haz_q[$];
  int    checks = 0;
  int    errors = 0;
  int    txn = 0;

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 49) == 0);
    s.stall = ($urandom_range(0, 7) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    s.valid = ($urandom_range(0, 4) != 0);
    s.pc    = $urandom;
    s.rsd   = $urandom;
    s.rtd   = $urandom;
    s.imm   = $urandom;
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom);
    s.funct = 6'($urandom);
    s.ctrl  = CTRL_W'($urandom);
    if ($urandom_range(0, 1) == 1) s.ctrl[MEM_READ] = 1'b1;
    return s;
  endfunction

  function automatic stim_t instr(input logic [CTRL_W-1:0] c, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [31:0] imm);
    stim_t s;
    s = rand_stim();
    s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b0; s.valid = 1'b1;
    s.ctrl = c; s.rs = rs; s.rt = rt; s.imm = imm;
    return s;
  endfunction

  // Reference: the EX slot as a record, advanced by the per-edge priority rules.
  task automatic step(input stim_t s);
    bit  haz;
    ex_t n;
    rst            = s.rst;
    bus.stall_i    = s.stall;
    bus.flush_i    = s.flush;
    bus.valid_i    = s.valid;
    bus.pc_plus4_i = s.pc;
    bus.rs_data_i  = s.rsd;
    bus.rt_data_i  = s.rtd;
    bus.imm_ext_i  = s.imm;
    bus.rs_i       = s.rs;
    bus.rt_i       = s.rt;
    bus.rd_i       = s.rd;
    bus.funct_i    = s.funct;
    bus.ctrl_i     = s.ctrl;
    haz = 1'b0;
    if (m_known) begin
      haz = m.valid && m.ctrl[MEM_READ] && s.valid && (m.rt != 0) &&
            ((m.rt == s.rs) ||
             ((m.rt == s.rt) && (s.ctrl[MEM_WRITE] || s.ctrl[BRANCH] || s.ctrl[REG_DST])));
      haz_q.push_back(haz);
    end
    n = m;
    if (s.rst) begin
      n = '{valid: 1'b0, pc: 0, rsd: 0, rtd: 0, imm: 0, rs: 0, rt: 0, rd: 0,
            funct: 0, ctrl: 0, chk_data: 1'b1};
    end else if (s.flush || (!s.stall && haz)) begin
      n.valid = 1'b0; n.ctrl = '0; n.chk_data = 1'b0;
    end else if (!s.stall) begin
      n.valid = s.valid;
      n.pc = s.pc; n.rsd = s.rsd; n.rtd = s.rtd;
      n.rs = s.rs; n.rt = s.rt; n.rd = s.rd; n.funct = s.funct;
      n.ctrl = s.valid ? s.ctrl : '0;
`ifdef IMM_ZERO_EXT_EN
      n.imm = s.ctrl[ZEXT] ? {16'h0000, s.imm[15:0]} : s.imm;
`else
      n.imm = s.imm;
`endif
      n.chk_data = 1'b1;
    end
    if (s.rst || m_known) begin
      st_q.push_back(n);
      m = n;
      m_known = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin : state_monitor
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        ex_t e;
        bit  bad;
        e = st_q.pop_front();
        checks++;
        txn++;
        bad = (bus.valid_o !== e.valid) || (bus.ctrl_o !== e.ctrl);
        if (e.chk_data)
          bad = bad || (bus.pc_plus4_o !== e.pc) || (bus.rs_data_o !== e.rsd) ||
                (bus.rt_data_o !== e.rtd) || (bus.imm_o !== e.imm) ||
                (bus.rs_o !== e.rs) || (bus.rt_o !== e.rt) || (bus.rd_o !== e.rd) ||
                (bus.funct_o !== e.funct);
        if (bad) begin
          errors++;
          $display("FAIL ex_state txn %0d: got v=%b ctrl=%h pc=%h rsd=%h rtd=%h imm=%h rs=%0d rt=%0d rd=%0d f=%h; want v=%b ctrl=%h pc=%h rsd=%h rtd=%h imm=%h rs=%0d rt=%0d rd=%0d f=%h (data checked=%b)",
                   txn, bus.valid_o, bus.ctrl_o, bus.pc_plus4_o, bus.rs_data_o, bus.rt_data_o,
                   bus.imm_o, bus.rs_o, bus.rt_o, bus.rd_o, bus.funct_o,
                   e.valid, e.ctrl, e.pc, e.rsd, e.rtd, e.imm, e.rs, e.rt, e.rd, e.funct, e.chk_data);
        end else begin
          $display("txn %0d ok valid=%b ctrl=%h imm=%h rt=%0d", txn, e.valid, e.ctrl, e.imm, e.rt);
        end
      end
    end
  end

  initial begin : hazard_monitor
    forever begin
      @(negedge clk);
      if (haz_q.size() > 0) begin
        bit h;
        h = haz_q.pop_front();
        checks++;
        if (bus.load_use_stall_o !== h) begin
          errors++;
          $display("FAIL load_use_stall at txn %0d: got %b want %b", txn, bus.load_use_stall_o, h);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    stim_t s;
    // Reset for two cycles with random data on the ID side.
    repeat (2) begin
      s = rand_stim();
      s.rst = 1'b1;
      step(s);
    end
    // Plain pass-through with a negative immediate.
    s = instr(C_ADD, 5'd1, 5'd2, 32'hFFFF_FF80);
    s.rsd = 32'h0000_0010;
    step(s);
    // lw $5 then dependent add: one bubble, then the held add is captured.
    step(instr(C_LW, 5'd1, 5'd5, 32'h0000_0004));
    s = instr(C_ADD, 5'd5, 5'd6, 32'h0);
    step(s);
    step(s);
    // A load into $0 never stalls.
    step(instr(C_LW, 5'd2, 5'd0, 32'h0000_0008));
    step(instr(C_ADD, 5'd0, 5'd3, 32'h0));
    // Flush with stall still bubbles.
    s = instr(C_ADD, 5'd1, 5'd2, 32'h1234);
    s.flush = 1'b1; s.stall = 1'b1;
    step(s);
    // Load a valid op, then freeze for three cycles against changing inputs.
    step(instr(C_ADD, 5'd7, 5'd8, 32'h5555_AAAA));
    repeat (3) begin
      s = rand_stim();
      s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1;
      step(s);
    end
    // Zero-extension candidate.
    step(instr(C_ORI, 5'd1, 5'd9, 32'hFFFF_8001));
    // Reset while a stall and a hazard are pending.
    step(instr(C_LW, 5'd1, 5'd4, 32'h0));
    s = instr(C_ADD, 5'd4, 5'd4, 32'h0);
    s.stall = 1'b1;
    step(s);
    s.rst = 1'b1;
    step(s);
    step(instr(C_ADD, 5'd4, 5'd1, 32'h0));
    // Random traffic.
    repeat (400) step(rand_stim());
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (st_q.size() != 0 || haz_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", st_q.size(), haz_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
